// File: rtl/load_pkg.sv
// rtl/load_pkg.sv - shared encodings and helpers for the load unit
package load_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ0 = 2'd1,
        ST_REQ1 = 2'd2,
        ST_DONE = 2'd3
    } load_state_e;

    // Access size in bytes; funct3[1:0] encodes log2(size) for every legal load.
    function automatic logic [3:0] size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic is_legal(input logic [2:0] funct3, input int xlen);
        case (funct3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
            F3_LD, F3_LWU:                       return (xlen == 64);
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - byte-lane selection and sign/zero extension of load data
module load_extract
    import load_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OFFW = $clog2(XLEN / 8)
) (
    input  logic [2*XLEN-1:0] data,    // {hi, lo} memory words, little-endian
    input  logic [OFFW-1:0]   off,     // byte offset of the access within lo
    input  logic [2:0]        funct3,  // load type
    output logic [XLEN-1:0]   result   // extended load value
);

    logic [OFFW+2:0] shamt;
    logic [XLEN-1:0] window;

    always_comb begin
        shamt  = {off, 3'b000};
        // Only the low XLEN bits after the shift can hold the addressed bytes.
        window = XLEN'(data >> shamt);
        case (funct3)
            F3_LB:   result = XLEN'($signed(window[7:0]));
            F3_LH:   result = XLEN'($signed(window[15:0]));
            F3_LW:   result = XLEN'($signed(window[31:0]));
            F3_LBU:  result = XLEN'(window[7:0]);
            F3_LHU:  result = XLEN'(window[15:0]);
            F3_LWU:  result = XLEN'(window[31:0]);
            default: result = window;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// rtl/load_unit.sv - load unit issuing aligned memory reads and returning extended results
module load_unit
    import load_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            reset,      // synchronous, active-high
    input  logic            ld_valid,   // load request valid
    output logic            ld_ready,   // idle and able to accept
    input  logic [31:0]     ld_addr,    // byte address
    input  logic [2:0]      ld_funct3,  // load type
    output logic            mem_req,    // registered read request
    output logic [31:0]     mem_addr,   // registered aligned read address
    input  logic            mem_ack,    // mem_rdata valid this cycle
    input  logic [XLEN-1:0] mem_rdata,  // read data, little-endian
    output logic            rd_valid,   // one-cycle result pulse
    output logic [XLEN-1:0] rd_data,    // extended result
    output logic            rd_fault    // qualifies rd_valid: illegal or misaligned
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    load_state_e     state_q, state_d;
    logic [OFFW-1:0] off_q, off_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            cross_q, cross_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic            mem_req_q, mem_req_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic            rd_valid_q, rd_valid_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;
    logic            rd_fault_q, rd_fault_d;

    logic [OFFW-1:0] req_off;
    logic [4:0]      req_span;
    logic            req_cross;
    logic            req_fault;
    logic [XLEN-1:0] ext_data;

    assign ld_ready = (state_q == ST_IDLE) && !reset;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_fault = rd_fault_q;

    // Decode of the incoming request, used only on the accept cycle.
    always_comb begin
        req_off   = ld_addr[OFFW-1:0];
        req_span  = 5'(req_off) + 5'(size_of(ld_funct3));
        req_cross = (req_span > 5'(NB));
        req_fault = !is_legal(ld_funct3, XLEN) || (req_cross && !ALLOW_MISALIGNED);
    end

    // Data words as they will be after this edge, so the result can be
    // extracted in the same cycle the final ack arrives.
    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (mem_ack && (state_q == ST_REQ0)) begin
            lo_d = mem_rdata;
        end
        if (mem_ack && (state_q == ST_REQ1)) begin
            hi_d = mem_rdata;
        end
    end

    load_extract #(
        .XLEN (XLEN),
        .OFFW (OFFW)
    ) u_extract (
        .data   ({hi_d, lo_d}),
        .off    (off_q),
        .funct3 (funct3_q),
        .result (ext_data)
    );

    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        funct3_d   = funct3_q;
        cross_d    = cross_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        rd_valid_d = 1'b0;
        rd_fault_d = 1'b0;
        rd_data_d  = rd_data_q;

        case (state_q)
            ST_IDLE: begin
                if (ld_valid) begin
                    off_d    = req_off;
                    funct3_d = ld_funct3;
                    cross_d  = req_cross;
                    if (req_fault) begin
                        state_d    = ST_DONE;
                        rd_valid_d = 1'b1;
                        rd_fault_d = 1'b1;
                        rd_data_d  = '0;
                    end else begin
                        state_d    = ST_REQ0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = ld_addr & ~32'(NB - 1);
                    end
                end
            end
            ST_REQ0: begin
                if (mem_ack) begin
                    if (cross_q) begin
                        // Request stays up; only the address moves to the next word.
                        state_d    = ST_REQ1;
                        mem_addr_d = mem_addr_q + 32'(NB);
                    end else begin
                        state_d    = ST_DONE;
                        mem_req_d  = 1'b0;
                        rd_valid_d = 1'b1;
                        rd_data_d  = ext_data;
                    end
                end
            end
            ST_REQ1: begin
                if (mem_ack) begin
                    state_d    = ST_DONE;
                    mem_req_d  = 1'b0;
                    rd_valid_d = 1'b1;
                    rd_data_d  = ext_data;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            off_q      <= '0;
            funct3_q   <= '0;
            cross_q    <= 1'b0;
            lo_q       <= '0;
            hi_q       <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_fault_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            funct3_q   <= funct3_d;
            cross_q    <= cross_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_fault_q <= rd_fault_d;
        end
    end

endmodule

// File: doc/load_unit.md
# load_unit

Parametrised load unit between the execute stage and the data-memory port. It accepts one load at a time through a valid/ready handshake and issues one or two aligned memory reads, splitting misaligned accesses when enabled. It then extracts the addressed byte, half, word or doubleword and returns it sign- or zero-extended to XLEN as a one-cycle result pulse. It generalises the load selector to byte offsets, unsigned loads, 64-bit datapaths and multi-cycle memory.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64
- ALLOW_MISALIGNED, 1, 1 = split accesses that cross an XLEN boundary; 0 = fault them

Ports (single clock; reset is synchronous and active-high):
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- ld_valid  in  1  load request valid
- ld_ready  out  1  unit idle and able to accept a request
- ld_addr  in  32  byte address
- ld_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011 LD and 110 LWU are legal only when XLEN=64
- mem_req  out  1  memory read request, registered
- mem_addr  out  32  aligned read address (low log2(XLEN/8) bits are 0), registered
- mem_ack  in  1  mem_rdata valid this cycle
- mem_rdata  in  XLEN  read data, little-endian
- rd_valid  out  1  one-cycle result pulse
- rd_data  out  XLEN  extended load result
- rd_fault  out  1  qualifies rd_valid: the request was illegal or misaligned

## Operation
- States: IDLE, REQ0, REQ1, DONE. ld_ready = (state==IDLE) && !reset.
- The request is captured on ld_valid && ld_ready, along with addr, funct3, off = addr[log2(XLEN/8)-1:0], size (1/2/4/8 bytes) and cross = (off+size > XLEN/8).
- Illegal funct3, or cross with ALLOW_MISALIGNED=0: go to DONE with fault=1. No memory request is issued.
- Otherwise go to REQ0 with mem_addr = addr & ~(XLEN/8-1).
- REQ0: mem_req=1 and held until mem_ack. On ack, mem_rdata is stored in lo. If cross, go to REQ1 with mem_addr += XLEN/8 (wraps modulo 2^32). If not cross, go to DONE.
- REQ1: mem_req=1 until mem_ack. On ack, mem_rdata is stored in hi, then go to DONE.
- DONE: rd_valid=1 and rd_fault=fault. rd_data = extend(({hi,lo} >> 8*off)[8*size-1:0]), or 0 on fault. Extension is signed for LB/LH/LW and zero for LBU/LHU/LWU; LD takes the full width. Next state is IDLE.
- rd_data holds its value until the next DONE. mem_addr holds when mem_req=0.
- mem_ack while in IDLE or DONE is ignored.
- Reset values: state IDLE; mem_req, mem_addr, rd_valid, rd_data, rd_fault, lo, hi all 0.
- Reset during REQ0/REQ1/DONE abandons the load: no rd_valid, and mem_req=0 from the cycle after the reset edge.

## Timing
- Cycle numbering: acceptance edge is T0, so the unit is in REQ0 during cycle T0+1.
- Aligned load, mem_ack in the first REQ0 cycle: rd_valid in cycle T0+2. Each cycle of ack delay adds 1.
- Split load, zero-wait acks: rd_valid in cycle T0+3.
- Fault: rd_valid and rd_fault in cycle T0+1, and mem_req never rises.
- Back-to-back: ld_ready returns in the cycle after DONE. Minimum spacing between accepts is 3 cycles aligned, 4 split.
- mem_req deasserts on the edge that samples mem_ack; the interface has no request pipelining.

## Structure
- Package load_pkg holds:
  - funct3 localparams (F3_LB…F3_LWU)
  - state encoding
  - function size_of(funct3) → byte count
  - function is_legal(funct3, XLEN)
- Sub-module load_extract is combinational. Inputs: {hi,lo} (2·XLEN), off, funct3. Output: the extended XLEN result. It also serves as the reusable extraction and extension stage.
- load_unit contains the FSM, capture registers and address generation.

## Test plan
- XLEN=32, LB addr 0x1003, word at 0x1000 = 0x80FF1234 → one mem_req at 0x1000; rd_data 0xFFFFFF80, rd_fault 0, rd_valid at T0+2.
- LHU addr 0x1002, word 0xBEEF0000, mem_ack delayed 3 cycles → mem_req held 4 cycles; rd_data 0x0000BEEF at T0+5.
- ALLOW_MISALIGNED=1, LW addr 0x1006, words 0x1004=0xAABBCCDD and 0x1008=0x11223344 → reads at 0x1004 then 0x1008; rd_data 0x3344AABB at T0+3.
- ALLOW_MISALIGNED=0, same LW; separately, funct3=011 with XLEN=32 → no mem_req; rd_valid and rd_fault in cycle T0+1; rd_data 0.
- XLEN=64: LWU addr 0x2004, doubleword 0xF0000001_00000000 → rd_data 0x00000000F0000001. LD addr 0x2000 → full doubleword.
- Reset asserted during REQ1 with mem_ack arriving later → mem_req=0 after the reset edge; no rd_valid; ld_ready=1 the cycle after reset deasserts; a new LW then completes normally.
